// File: rtl/conv_out_collector.sv
// Tail of the systolic convolution row chain: drops fill/border samples, adds bias,
// saturates, optionally applies ReLU and writes each full-window result in raster order.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; incoming samples ignored
// S_FILL    | discarding FILL_LAT row-chain fill samples
// S_COLLECT | scanning IMG_W x IMG_W samples, writing full-window ones
// S_DONE    | one cycle after the last sample; raises done, drops busy
module conv_out_collector #(
  parameter int DATA_W   = 16,
  parameter int IMG_W    = 28,
  parameter int K        = 5,
  parameter int FILL_LAT = 25,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] psum_in,
  input  logic [DATA_W-1:0] bias,
  input  logic              relu_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int FW = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] EDGE      = CW'(K - 1);
  localparam logic [FW-1:0] FILL_LOAD = FW'((FILL_LAT > 0) ? FILL_LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COLLECT, S_DONE} state_t;

  state_t            state;
  logic [FW-1:0]     fill_cnt;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] bias_reg;
  logic              relu_reg;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              keep;

  assign sum  = {psum_in[DATA_W-1], psum_in} + {bias_reg[DATA_W-1], bias_reg};
  assign keep = (row >= EDGE) && (col >= EDGE);

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    result = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1])
      result = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    if (relu_reg && sum[DATA_W])
      result = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      row      <= '0;
      col      <= '0;
      wr_addr  <= '0;
      bias_reg <= '0;
      relu_reg <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      out_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bias_reg <= bias;
            relu_reg <= relu_en;
            busy     <= 1'b1;
            fill_cnt <= FILL_LOAD;
            row      <= '0;
            col      <= '0;
            wr_addr  <= '0;
            state    <= (FILL_LAT == 0) ? S_COLLECT : S_FILL;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            if (fill_cnt == '0) state <= S_COLLECT;
            else                fill_cnt <= fill_cnt - 1'b1;
          end
        end
        S_COLLECT: begin
          if (in_valid) begin
            // Kept samples arrive in raster order, so a running count is the address.
            if (keep) begin
              out_we   <= 1'b1;
              out_addr <= wr_addr;
              out_data <= result;
              wr_addr  <= wr_addr + 1'b1;
            end
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) state <= S_DONE;
              else             row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Self-checking bench for conv_out_collector: reference model derived from the window
// and saturation rules, constant-psum vector table, random and gapped maps, reset abort.
module tb_conv_out_collector;

  localparam int DATA_W   = 16;
  localparam int IMG_W    = 28;
  localparam int K        = 5;
  localparam int FILL_LAT = 25;
  localparam int ADDR_W   = 10;
  localparam int OUT_W    = IMG_W - K + 1;
  localparam int NPIX     = IMG_W * IMG_W;
  localparam int NOUT     = OUT_W * OUT_W;
  localparam int TOTAL    = FILL_LAT + NPIX;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] psum_in = '0;
  logic [DATA_W-1:0] bias = '0;
  logic              relu_en = 1'b0;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  conv_out_collector #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .K(K), .FILL_LAT(FILL_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .psum_in(psum_in),
    .bias(bias), .relu_en(relu_en), .out_we(out_we), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cap_a[$];
  int cap_d[$];
  int exp_a[$];
  int exp_d[$];
  logic [15:0] samp[$];

  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int busy_at_done = 0;
  int gap_err = 0;
  logic prev_iv = 1'b0;

  // Outputs observed mid-cycle; prev_iv is the in_valid the DUT sampled one edge earlier.
  always @(negedge clk) begin
    if (out_we) begin
      cap_a.push_back(int'(out_addr));
      cap_d.push_back(int'(out_data));
      last_we_cyc = cyc;
      if (!prev_iv) gap_err++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) busy_at_done++;
    end
    prev_iv = in_valid;
    cyc++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  function automatic int ref_val(input logic [15:0] p, input logic [15:0] b, input bit r);
    int s;
    s = int'($signed(p)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (r && s < 0) s = 0;
    return s & 32'hFFFF;
  endfunction

  // Expected writes straight from the window rule over the sample stream.
  task automatic build_model(input logic [15:0] b, input bit r);
    int j, rw, cl;
    exp_a.delete();
    exp_d.delete();
    for (int i = FILL_LAT; i < TOTAL; i++) begin
      j  = i - FILL_LAT;
      rw = j / IMG_W;
      cl = j % IMG_W;
      if (rw >= K - 1 && cl >= K - 1) begin
        exp_a.push_back((rw - K + 1) * OUT_W + (cl - K + 1));
        exp_d.push_back(ref_val(samp[i], b, r));
      end
    end
  endtask

  task automatic run_map(input string tag, input logic [15:0] b, input bit r, input int mode,
                         input logic [15:0] pc, input int duty, input bit disturb,
                         output int base_o);
    int base_w, base_done, base_bd, base_gap, i, guard, nw, nmis, lim;
    samp.delete();
    for (int k = 0; k < TOTAL; k++)
      samp.push_back(mode == 0 ? 16'(k) : (mode == 1 ? pc : 16'($urandom)));
    build_model(b, r);
    base_w    = cap_a.size();
    base_done = done_cnt;
    base_bd   = busy_at_done;
    base_gap  = gap_err;
    base_o    = base_w;
    chk({tag, "_busy_idle"}, int'(busy), 0);
    bias = b; relu_en = r; start = 1'b1; in_valid = 1'b1; psum_in = 16'hDEAD;
    tick;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    i = 0; guard = 0;
    while (i < TOTAL && guard < 30000) begin
      in_valid = ($urandom_range(99) < duty);
      if (in_valid) begin
        psum_in = samp[i];
        i++;
      end else begin
        psum_in = 16'($urandom);
      end
      if (disturb) begin
        start   = ($urandom_range(19) == 0);
        relu_en = 1'($urandom_range(1));
        bias    = 16'($urandom);
      end
      tick;
      guard++;
    end
    in_valid = 1'b0; start = 1'b0; relu_en = 1'b0;
    chk({tag, "_samples_fed"}, i, TOTAL);
    repeat (4) tick;
    nw = cap_a.size() - base_w;
    chk({tag, "_write_count"}, nw, NOUT);
    lim = (nw < NOUT) ? nw : NOUT;
    nmis = 0;
    for (int k = 0; k < lim; k++) begin
      if (cap_a[base_w + k] != exp_a[k] || cap_d[base_w + k] != exp_d[k]) begin
        if (nmis == 0)
          $display("  first difference at write %0d: addr %0d data 0x%0h, model addr %0d data 0x%0h",
                   k, cap_a[base_w + k], cap_d[base_w + k], exp_a[k], exp_d[k]);
        nmis++;
      end
    end
    chk({tag, "_pair_mismatches"}, nmis, 0);
    chk({tag, "_done_pulses"}, done_cnt - base_done, 1);
    chk({tag, "_done_delay"}, done_cyc - last_we_cyc, 1);
    chk({tag, "_busy_at_done"}, busy_at_done - base_bd, 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_write_after_gap"}, gap_err - base_gap, 0);
  endtask

  typedef struct {
    logic [15:0] psum;
    logic [15:0] b;
    bit          r;
    logic [15:0] expd;
  } vec_t;

  vec_t vt[7];

  initial begin
    int base, idx, guard, nbad, n_at_rst, c136, c140;
    string nm;

    vt[0] = '{16'h2000, 16'h7000, 1'b0, 16'h7FFF};
    vt[1] = '{16'hA000, 16'h9000, 1'b0, 16'h8000};
    vt[2] = '{16'hA000, 16'h9000, 1'b1, 16'h0000};
    vt[3] = '{16'h0005, 16'hFFFD, 1'b0, 16'h0002};
    vt[4] = '{16'hFFFB, 16'h0001, 1'b1, 16'h0000};
    vt[5] = '{16'hFFFB, 16'h0001, 1'b0, 16'hFFFC};
    vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000};

    repeat (3) tick;
    chk("reset_out_we", int'(out_we), 0);
    chk("reset_out_addr", int'(out_addr), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    tick;

    // Idle samples must not start or disturb anything.
    in_valid = 1'b1; psum_in = 16'h1234;
    repeat (5) tick;
    in_valid = 1'b0;
    chk("idle_no_writes", cap_a.size(), 0);

    // Abort a map with reset after 300 writes.
    bias = 16'h0000; relu_en = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    base = cap_a.size(); idx = 0; guard = 0;
    while (cap_a.size() - base < 300 && guard < 2000) begin
      in_valid = 1'b1; psum_in = 16'(idx); idx++;
      tick;
      guard++;
    end
    chk("abort_reached_300", int'(cap_a.size() - base >= 300), 1);
    rst = 1'b1;
    #1;
    chk("abort_out_we", int'(out_we), 0);
    chk("abort_out_addr", int'(out_addr), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    n_at_rst = cap_a.size();
    tick; tick;
    rst = 1'b0;
    repeat (5) tick;
    in_valid = 1'b0;
    chk("abort_no_later_writes", cap_a.size() - n_at_rst, 0);
    run_map("restart", 16'h0000, 1'b0, 0, 16'h0, 100, 1'b0, base);
    chk("restart_first_addr", (cap_a.size() > base) ? cap_a[base] : -1, 0);

    // Full map, psum = sample index; also the border drop/keep points.
    run_map("full", 16'h0000, 1'b0, 0, 16'h0, 100, 1'b0, base);
    chk("full_first_addr", (cap_a.size() > base) ? cap_a[base] : -1, 0);
    chk("full_first_data", (cap_a.size() > base) ? cap_d[base] : -1, FILL_LAT + 4 * IMG_W + 4);
    chk("full_last_addr", (cap_a.size() >= base + NOUT) ? cap_a[base + NOUT - 1] : -1, NOUT - 1);
    chk("full_last_data", (cap_d.size() >= base + NOUT) ? cap_d[base + NOUT - 1] : -1,
        FILL_LAT + NPIX - 1);
    c136 = 0; c140 = 0;
    for (int k = base; k < cap_d.size(); k++) begin
      if (cap_d[k] == FILL_LAT + 3 * IMG_W + 27) c136++;
      if (cap_d[k] == FILL_LAT + 4 * IMG_W + 3) c140++;
    end
    chk("border_r3c27_dropped", c136, 0);
    chk("border_r4c3_dropped", c140, 0);

    // Saturation / ReLU vector table.
    foreach (vt[v]) begin
      nm = $sformatf("vec%0d", v);
      run_map(nm, vt[v].b, vt[v].r, 1, vt[v].psum, 100, 1'b0, base);
      nbad = 0;
      for (int k = base; k < cap_d.size(); k++)
        if (cap_d[k] != int'(vt[v].expd)) nbad++;
      chk({nm, "_table_data"}, nbad, 0);
    end

    run_map("gaps", 16'h0000, 1'b0, 0, 16'h0, 30, 1'b0, base);
    run_map("rand_a", 16'($urandom), 1'b0, 2, 16'h0, 70, 1'b0, base);
    run_map("rand_b", 16'($urandom), 1'b1, 2, 16'h0, 55, 1'b0, base);
    run_map("control", 16'hF800, 1'b1, 2, 16'h0, 80, 1'b1, base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
